// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 8;
  localparam int DEFAULT_DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle
// (high) level so a reset never looks like a start edge.
module rx_sync (
  input  logic clock_IN,
  input  logic reset_n_IN,
  input  logic async_IN,
  output logic sync_OUT
);

  logic meta;

  always_ff @(posedge clock_IN or negedge reset_n_IN) begin
    if (!reset_n_IN) begin
      meta     <= 1'b1;
      sync_OUT <= 1'b1;
    end else begin
      meta     <= async_IN;
      sync_OUT <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at half a bit, then
// one sample per bit period, LSB first. Optional even parity: UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clock_IN,
  input  logic                 reset_n_IN,
  input  logic                 sample_tick_IN,
  input  logic                 rx_IN,
  output logic [DATA_BITS-1:0] data_OUT,
  output logic                 data_valid_OUT,
  output logic                 frame_err_OUT,
  output logic                 busy_OUT
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_OUT
`endif
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next, data_next;
  logic                 armed, armed_next;
  logic                 valid_next, ferr_next;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad, parity_bad_next, perr_next;
`endif

  rx_sync u_sync (
    .clock_IN  (clock_IN),
    .reset_n_IN(reset_n_IN),
    .async_IN  (rx_IN),
    .sync_OUT  (rx_s)
  );

  assign busy_OUT = (state != IDLE);

  always_ff @(posedge clock_IN or negedge reset_n_IN) begin
    if (!reset_n_IN) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      armed          <= 1'b0;
      data_OUT       <= '0;
      data_valid_OUT <= 1'b0;
      frame_err_OUT  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad     <= 1'b0;
      parity_err_OUT <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      tick_cnt       <= tick_next;
      bit_cnt        <= bit_next;
      shift_reg      <= shift_next;
      armed          <= armed_next;
      data_OUT       <= data_next;
      data_valid_OUT <= valid_next;
      frame_err_OUT  <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_bad     <= parity_bad_next;
      parity_err_OUT <= perr_next;
`endif
    end
  end

  // Everything advances only on sample ticks; pulses are registered so they
  // appear on the clock after the sampling tick.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    armed_next = armed;
    data_next  = data_OUT;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad;
    perr_next       = 1'b0;
`endif
    if (sample_tick_IN) begin
      case (state)
        IDLE: begin
          if (!armed) begin
            armed_next = rx_s;
          end else if (!rx_s) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_next = '0;
            bit_next  = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_next  = '0;
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == FULL_LAST) begin
            tick_next       = '0;
            parity_bad_next = rx_s ^ (^shift_reg);
            state_next      = STOP;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
`endif
        // A low stop bit leaves start detection disarmed, so a held break
        // yields a single frame error until the line goes high again.
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_next  = '0;
            state_next = IDLE;
            armed_next = rx_s;
            ferr_next  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_next       = parity_bad;
            parity_bad_next = 1'b0;
            if (rx_s && !parity_bad) begin
`else
            if (rx_s) begin
`endif
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven tick-aligned and the
// expected pulse/data pair is queued, then matched when the DUT pulses.
module tb_uart_rx;

  localparam int OS = 8;
  localparam int DB = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data;
  logic          valid, ferr, busy;
  logic          perrObs;
`ifdef UART_RX_PARITY_EN
  logic          perr;
  assign perrObs = perr;
`else
  assign perrObs = 1'b0;
`endif

  typedef struct {
    logic [2:0]    flags;
    logic [DB-1:0] data;
  } exp_t;

  exp_t          expQ[$];
  logic [DB-1:0] lastGood = '0;
  int            checks = 0;
  int            failures = 0;
  int            tickPeriod = 651;
  int            tickCount = 0;
  int            fallTick = 0;
  bit            measureLatency = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock_IN      (clock),
    .reset_n_IN    (reset_n),
    .sample_tick_IN(tick),
    .rx_IN         (rx),
    .data_OUT      (data),
    .data_valid_OUT(valid),
    .frame_err_OUT (ferr),
    .busy_OUT      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_OUT(perr)
`endif
  );

  always #10 clock = ~clock;

  // Tick pulse one clock wide every tickPeriod clocks.
  initial begin
    forever begin
      repeat (tickPeriod - 1) @(posedge clock);
      #1 tick = 1'b1;
      @(posedge clock);
      #1 tick = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitTicks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clock);
      if (tick) k++;
    end
    #1;
  endtask

  // Drives one frame; flags are {parity_err, frame_err, data_valid}.
  task automatic applyStimulus(input logic [DB-1:0] value, input logic stopBit,
                               input logic badParity);
    exp_t e;
    logic perrExp;
    perrExp    = badParity;
    e.flags    = {perrExp, !stopBit, stopBit && !perrExp};
    if (e.flags[0]) lastGood = value;
    e.data     = lastGood;
    expQ.push_back(e);
    rx       = 1'b0;
    fallTick = tickCount;
    waitTicks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = value[i];
      waitTicks(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx = badParity ? ~(^value) : ^value;
    waitTicks(OS);
`endif
    rx = stopBit;
    waitTicks(OS);
  endtask

  initial begin
    logic [DB-1:0] partial;
    fork
      forever begin
        @(posedge clock);
        if (tick) tickCount++;
      end
      forever begin
        exp_t e;
        @(negedge clock);
        if (valid || ferr || perrObs) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse", {29'd0, perrObs, ferr, valid}, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("pulse_flags", {29'd0, perrObs, ferr, valid}, {29'd0, e.flags});
            checkOutput("data_out", data, e.data);
            if (measureLatency && valid) begin
              checkOutput("latency_ticks", tickCount - fallTick - 1, 76);
              measureLatency = 1'b0;
            end
          end
        end
      end
    join_none

    repeat (5) @(posedge clock);
    #1;
    checkOutput("reset_data", data, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_ferr", ferr, 0);
    checkOutput("reset_busy", busy, 0);
    reset_n = 1'b1;
    waitTicks(2);

    $display("[TB] frame 0xA5 at 651-clock ticks");
    measureLatency = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    rx = 1'b1;
    tickPeriod = 8;
    waitTicks(8);

    $display("[TB] two-tick glitch");
    rx = 1'b0;
    waitTicks(2);
    rx = 1'b1;
    waitTicks(2);
    checkOutput("glitch_busy_mid", busy, 1);
    waitTicks(1);
    checkOutput("glitch_busy_end", busy, 0);
    waitTicks(16);

    $display("[TB] frame error, back-to-back, break");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    waitTicks(16);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    waitTicks(16);
    expQ.push_back('{flags: 3'b010, data: lastGood});
    rx = 1'b0;
    waitTicks(OS * 30);
    rx = 1'b1;
    waitTicks(16);

    $display("[TB] reset mid-frame");
    partial = 8'h81;
    rx = 1'b0;
    waitTicks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      waitTicks(OS);
    end
    reset_n  = 1'b0;
    rx       = 1'b1;
    lastGood = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("midreset_data", data, 0);
    checkOutput("midreset_busy", busy, 0);
    reset_n = 1'b1;
    waitTicks(16);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    rx = 1'b1;
    waitTicks(16);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity error frame");
    applyStimulus(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    waitTicks(16);
`endif

    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 8, sample ticks per bit.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame.
REQ-003 clock_IN  input  1  system clock (50 MHz); one clock, all logic on posedge.
REQ-004 reset_n_IN  input  1  asynchronous, active-low reset.
REQ-005 sample_tick_IN  input  1  one-clock_IN-wide enable pulse at OVERSAMPLE x baud (76,800 Hz for 9600 baud), produced by the upstream divider.
REQ-006 rx_IN  input  1  asynchronous serial line, idle high.
REQ-007 data_OUT  output  DATA_BITS  last good received byte.
REQ-008 data_valid_OUT  output  1  one-clock pulse, data_OUT updated this cycle.
REQ-009 frame_err_OUT  output  1  one-clock pulse, stop bit sampled low.
REQ-010 busy_OUT  output  1  high in any state other than IDLE.

Function
REQ-011 rx_IN SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-012 Tick counter and bit counter SHALL advance only on clocks where sample_tick_IN=1.
REQ-013 States SHALL be IDLE, START, DATA, STOP (plus PARITY when configured).
REQ-014 IDLE: start detection SHALL arm only after the line has been sampled high on at least one tick; an armed low sample moves to START with tick count cleared.
REQ-015 START: at tick OVERSAMPLE/2 (4), a high sample returns to IDLE (false start, no outputs); a low sample enters DATA with tick and bit counts cleared.
REQ-016 DATA: each OVERSAMPLE ticks, sample one bit and shift it in LSB first; after DATA_BITS samples, enter STOP (or PARITY).
REQ-017 STOP: after OVERSAMPLE ticks, sample; high -> load data_OUT, pulse data_valid_OUT; low -> pulse frame_err_OUT, data_OUT unchanged; both return to IDLE.
REQ-018 Pulses SHALL assert on the clock after the sampling tick and last exactly one clock.
REQ-019 Latency: start-edge detection to stop sample = OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE ticks (76 at defaults).
REQ-020 A break (line held low) SHALL produce exactly one frame_err_OUT and no further frames until the line returns high.
REQ-021 Back-to-back frames SHALL be received with no idle gap beyond the stop bit.
REQ-022 Counters SHALL wrap only by explicit clear; widths SHALL be $clog2 of their limits.

Reset
REQ-023 Asserting reset_n_IN low SHALL immediately force IDLE, counters 0, shift register 0, synchronizer flops 1, data_OUT 0, all pulse outputs 0, busy_OUT 0, and disarm start detection.
REQ-024 Reset mid-frame SHALL discard the partial frame without any pulse.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state after DATA samples an even-parity bit; mismatch pulses output parity_err_OUT (1 bit) alongside the stop-bit result and suppresses data_valid_OUT; latency adds OVERSAMPLE ticks.
REQ-026 Macro undefined: no PARITY state, no parity_err_OUT port, frame = start + DATA_BITS + stop.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum type and default OVERSAMPLE and DATA_BITS constants.
REQ-028 Sub-module rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification
REQ-029 Frame 0xA5 at 9600 baud, ticks every 651 clocks -> data_OUT=0xA5, single data_valid_OUT pulse 76 ticks after start edge.
REQ-030 Low glitch 2 ticks wide on idle line -> no pulse, busy_OUT returns low at tick 4.
REQ-031 Frame 0x3C with stop bit 0 -> frame_err_OUT pulse, data_OUT retains previous 0xA5.
REQ-032 Frames 0x00 then 0xFF back-to-back -> two valid pulses, data 0x00 then 0xFF.
REQ-033 reset_n_IN low at bit 4 of 0x81, then frame 0x5A -> no pulse for 0x81, 0x5A received correctly.
REQ-034 UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err_OUT pulse, no data_valid_OUT.
